// File: rtl/sklansky_seq_ctrl.sv
// Serial WIDTH-bit add/subtract over one shared 4-bit Sklansky slice, LS nibble first; done arrives NSLICE edges after start.
// No backpressure: start is taken only outside RUN, there is no queueing, and results are held until the next completion.

module sklansky_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g, p;
  logic g10, p10, g32, p32, g20, p20, g30, p30;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Sklansky prefix tree: pairs first, then fan the low pair into the upper bits.
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g20 = g[2] | (p[2] & g10);
  assign p20 = p[2] & p10;
  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g10 | (p10 & cin);
  assign c[3] = g20 | (p20 & cin);
  assign cout = g30 | (p30 & cin);
  assign s    = p ^ c;
endmodule

module sklansky_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSLICE = WIDTH / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q, b_q, res, res_nxt;
  logic             cy;
  logic [3:0]       sl_a, sl_b, sl_s;
  logic             sl_co;
  logic             last;

  always_comb begin
    sl_a = 4'h0;
    sl_b = 4'h0;
    for (int i = 0; i < NSLICE; i++) begin
      if (k == KW'(i)) begin
        sl_a = a_q[i*4 +: 4];
        sl_b = b_q[i*4 +: 4];
      end
    end
  end

  sklansky_add4 u_add (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (cy),
    .s    (sl_s),
    .cout (sl_co)
  );

  always_comb begin
    res_nxt = res;
    for (int i = 0; i < NSLICE; i++) begin
      if (k == KW'(i)) res_nxt[i*4 +: 4] = sl_s;
    end
  end

  assign last = (k == KW'(NSLICE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res   <= '0;
      cy    <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // b is stored pre-inverted for subtract so RUN only ever adds.
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            cy    <= cin ^ sub;
            k     <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res <= res_nxt;
          cy  <= sl_co;
          if (last) begin
            state <= DONE;
            k     <= '0;
            sum   <= res_nxt;
            cout  <= sl_co;
            ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: doc/sklansky_seq_ctrl.md
# sklansky_seq_ctrl

Sequencing controller that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit `Sklansky` prefix-adder slice over successive nibbles, least-significant first. A registered carry links the slices. The block sits between a requester using a start/done handshake and the shared 4-bit adder datapath, which it instantiates once. Its outputs are the full sum, the carry-out and the signed overflow.

## Interface
- `WIDTH`, 16, operand width in bits; must be a multiple of 4 and at least 4. NSLICE = WIDTH/4.
- `clk`  in  1  clock; rising-edge active.
- `rst`  in  1  reset; one clock; asynchronous, active-high.
- `start`  in  1  request; sampled only while `busy`=0.
- `sub`  in  1  0 = add (a+b+cin); 1 = subtract (a−b−cin).
- `cin`  in  1  carry/borrow in.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `busy`  out  1  high while slices are being computed.
- `done`  out  1  one-cycle pulse; results are valid.
- `sum`  out  WIDTH  result; held until the next completion.
- `cout`  out  1  raw carry out of the MSB slice. In subtract, 1 = no borrow.
- `ovf`  out  1  two's-complement overflow.

## Operation
- FSM states are IDLE, RUN and DONE. Reset places the FSM in IDLE.
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0. The slice counter, carry register and operand latches are cleared.
- Start acceptance: when `start`=1 at a rising edge in IDLE or DONE:
  - latch `a`, `b` and `sub`;
  - b' = b XOR {WIDTH{sub}};
  - carry register = cin XOR sub;
  - slice counter k = 0;
  - go to RUN.
- While in RUN, the adder is driven with:
  - A = a[4k+3:4k];
  - B = b'[4k+3:4k];
  - Cin = carry register.
- At each RUN edge, the slice Sum is written into result nibble k, the carry register takes Cout and k increments.
- When k = NSLICE−1 at an edge, the block goes to DONE instead of incrementing. On that same edge:
  - `sum` ← full result;
  - `cout` ← final Cout;
  - `ovf` ← (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]).
- DONE lasts one cycle, with `done`=1. The next state is RUN if `start`=1 (back-to-back), otherwise IDLE.
- `start` during RUN is ignored. There is no queueing.
- `a`, `b`, `sub` and `cin` may change freely after acceptance, because only the latched copies are used.
- `sum`, `cout` and `ovf` change only on the edge entering DONE, or on reset. Partial results are never visible.
- Reset during RUN aborts immediately: all outputs return to reset values, no `done` is issued and the latched operands are discarded.
- WIDTH=4: a single RUN cycle, so latency = 1 edge.

## Timing
- E0: the edge at which `start` is accepted. `busy` rises after E0.
- Edges E1..E_NSLICE compute slices 0..NSLICE−1, one per clock.
- After E_NSLICE:
  - `busy`=0;
  - `done`=1 for exactly one cycle;
  - results are valid.
- Latency is NSLICE edges from acceptance to `done` (4 for WIDTH=16).
- Peak throughput is one operation per NSLICE+1 cycles. A restart can be accepted at the DONE edge.
- `busy` = (state == RUN). `done` = (state == DONE). Both are registered state decodes, with no combinational path from inputs.
- The adder path is combinational within one cycle: slice output to carry register is a single-cycle path.

## Test plan
- Basic add, WIDTH=16: a=0x1234, b=0x4321, cin=0, sub=0 → sum=0x5555, cout=0, ovf=0. `done` after exactly 4 edges; `busy` high for 4 cycles.
- Full carry chain: a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0. Also a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
  - a=0x0005, b=0x0002, sub=1, cin=1 → sum=0x0002, cout=1.
- Handshake:
  - `start` held high continuously → `done` pulses every 5 cycles.
  - A `start` pulse in mid-RUN with new operands is ignored; the result matches the first operands.
  - Changing `a`/`b` after E0 does not affect the result.
- Reset mid-operation: assert `rst` after E2 → `busy`, `done`, `sum`, `cout` and `ovf` go to 0 immediately and no `done` follows. A subsequent start with a=0x0001, b=0x0001 → sum=0x0002 after 4 edges.
- WIDTH=4 build: a=0xD, b=0xB, cin=0 → sum=0x8, cout=1, ovf=0, `done` 1 edge after acceptance. Also a=0xF, b=0xF, cin=1 → sum=0xF, cout=1.
